// File: rtl/adc_sched_pkg.sv
// Shared types and default widths for the ADC burst scheduler.
package adc_sched_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StConv
   } sched_state_e;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefCntW  = 16;
   localparam int unsigned DefPerW  = 16;

endpackage

// File: rtl/adc_period_timer.sv
// Start-to-start period down-counter; expired once the loaded interval has elapsed.
module adc_period_timer #(
   parameter int unsigned PER_W = 16
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             load,
   input  logic [PER_W-1:0] period,
   output logic             expired
);

   logic [PER_W-1:0] cnt_q;

   // Loading P-1 makes expiry land exactly P cycles after the load cycle; 0 behaves as 1.
   always_ff @(posedge aclk) begin
      if (areset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= (period == '0) ? '0 : period - 1'b1;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/adc_burst_sched.sv
// Burst scheduler: paces ADC conversions at a fixed period and streams results
// through a single-entry output register with overrun detection.
module adc_burst_sched
   import adc_sched_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned CNT_W  = DefCntW,
   parameter int unsigned PER_W  = DefPerW
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [PER_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   output logic              conv_start,
   input  logic              conv_done,
   input  logic [DATA_W-1:0] conv_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   sched_state_e     state_q;
   logic [PER_W-1:0] period_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] smp_cnt_q;
   logic             stop_pend_q;

   logic             expired;
   logic             start_go;
   logic             fire;
   logic             timer_load;
   logic [PER_W-1:0] timer_period;
   logic [CNT_W-1:0] smp_next;
   logic             last_smp;
   logic             accept;

   always_comb begin
      start_go     = (state_q == StIdle) && cmd_start && !cmd_stop;
      fire         = (state_q == StArm) && !cmd_stop && expired;
      timer_load   = start_go || fire;
      // A zero load on start leaves the timer expired so the first conversion fires at once.
      timer_period = fire ? period_q : '0;
      smp_next     = (&smp_cnt_q) ? smp_cnt_q : smp_cnt_q + 1'b1;
      last_smp     = ((count_q != '0) && (smp_next == count_q)) || stop_pend_q || cmd_stop;
      accept       = !m_valid || m_ready;
   end

   adc_period_timer #(
      .PER_W (PER_W)
   ) u_timer (
      .aclk    (aclk),
      .areset  (areset),
      .load    (timer_load),
      .period  (timer_period),
      .expired (expired)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= StIdle;
         period_q    <= '0;
         count_q     <= '0;
         smp_cnt_q   <= '0;
         stop_pend_q <= 1'b0;
         conv_start  <= 1'b0;
         m_valid     <= 1'b0;
         m_data      <= '0;
         m_last      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         conv_start <= 1'b0;
         done       <= 1'b0;
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               if (start_go) begin
                  period_q    <= cfg_period;
                  count_q     <= cfg_count;
                  smp_cnt_q   <= '0;
                  stop_pend_q <= 1'b0;
                  overrun     <= 1'b0;
                  busy        <= 1'b1;
                  state_q     <= StArm;
               end
            end
            StArm: begin
               if (cmd_stop) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StIdle;
               end else if (expired) begin
                  conv_start <= 1'b1;
                  state_q    <= StConv;
               end
            end
            StConv: begin
               if (cmd_stop) begin
                  stop_pend_q <= 1'b1;
               end
               if (conv_done) begin
                  smp_cnt_q <= smp_next;
                  if (accept) begin
                     m_valid <= 1'b1;
                     m_data  <= conv_data;
                     m_last  <= last_smp;
                  end else begin
                     overrun <= 1'b1;
                  end
                  if (last_smp) begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     state_q <= StArm;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
